// File: rtl/lh_pkg.sv
// Shared definitions for the streaming light hash: AES S-box, byte rotate,
// default chaining value, FSM state encoding and a golden digest model.
package lh_pkg;

   localparam logic [63:0] LH_DEFAULT_IV = 64'h34550F14DAC02BEE;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      ROUND  = 2'd1,
      DONE   = 2'd2,
      DRAIN  = 2'd3
   } lh_state_e;

   localparam logic [7:0] LH_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      return LH_SBOX[x];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] r);
      logic [15:0] d;
      d = {x, x} << r;
      return d[15:8];
   endfunction

   // Digest of msg bytes 0..len-1 (byte i at msg[8*i +: 8]) for an n-byte
   // state, n <= 16; the result is right-aligned in 128 bits.
   function automatic logic [127:0] lh_ref_digest(input logic [127:0] iv, input int n,
                                                  input logic [511:0] msg, input int len);
      logic [127:0] h;
      logic [127:0] t;
      int src;
      h = '0;
      for (int j = 0; j < n; j++) h[8*(n-1-j) +: 8] = iv[8*(n-1-j) +: 8];
      for (int i = 0; i < len; i++) begin
         t = h;
         for (int j = 0; j < n; j++) begin
            src = (j + 2) % n;
            t[8*(n-1-j) +: 8] = aes_sbox(rotl8(h[8*(n-1-src) +: 8] ^ msg[8*i +: 8], 3'(j % 8)));
         end
         h = t;
      end
      return h;
   endfunction

endpackage

// File: rtl/lh_stream_hasher_if.sv
// Byte stream in, digest out. valid/ready: a transfer happens on a rising
// edge where both are high; the sender holds data stable while valid waits.
interface lh_stream_hasher_if #(
   parameter int DIGEST_BYTES = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [7:0]                in_data;
   logic                      in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [8*DIGEST_BYTES-1:0] out_digest;
   logic [15:0]               out_len;
   logic                      err;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_digest, out_len, err
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_digest, out_len, err
   );
endinterface

// File: rtl/lh_sbox_lane.sv
// One S-box lane: XOR message byte into a state byte, rotate, substitute.
module lh_sbox_lane
   import lh_pkg::*;
(
   input  logic [7:0] src,
   input  logic [7:0] m,
   input  logic [2:0] rot,
   output logic [7:0] res
);
   assign res = aes_sbox(rotl8(src ^ m, rot));
endmodule

// File: rtl/lh_stream_hasher.sv
// Streaming light hash, LANES S-box lookups per cycle, N/LANES cycles per byte.
// Define LH_INPUT_FILTER_EN to reject bytes outside 0x20..0x7E / 0xA1..0xFF.
module lh_stream_hasher
   import lh_pkg::*;
#(
   parameter int DIGEST_BYTES = 8,
   parameter int LANES        = 1,
   parameter int MAX_LEN      = 32,
   parameter logic [8*DIGEST_BYTES-1:0] IV = (8*DIGEST_BYTES)'(LH_DEFAULT_IV)
)(
   input  logic      clk,
   input  logic      rst,
   lh_stream_hasher_if.slave bus,
   output lh_state_e fsm_state
);
   localparam int K  = DIGEST_BYTES / LANES;
   localparam int RW = (K > 1) ? $clog2(K) : 1;

   lh_state_e                 state;
   logic [RW-1:0]             rnd;
   logic [8*DIGEST_BYTES-1:0] h;
   logic [8*DIGEST_BYTES-1:0] shadow;
   logic [8*DIGEST_BYTES-1:0] next_h;
   logic [8*LANES-1:0]        lane_out;
   logic [7:0]                msg_byte;
   logic                      last_q;
   logic [15:0]               len;
   logic                      hs;
   logic                      bad;

   assign hs        = bus.in_valid && bus.in_ready;
   assign fsm_state = state;

`ifdef LH_INPUT_FILTER_EN
   assign bad = !(((bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E)) || (bus.in_data >= 8'hA1));
`else
   assign bad = 1'b0;
`endif

   // Lane l in round cycle rnd owns state byte j = rnd*LANES + l.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      int unsigned j_idx;
      int unsigned s_idx;
      assign j_idx = int'(rnd) * LANES + l;
      assign s_idx = (j_idx + 2) % DIGEST_BYTES;
      lh_sbox_lane u_lane (
         .src (h[8*(DIGEST_BYTES-1-s_idx) +: 8]),
         .m   (msg_byte),
         .rot (j_idx[2:0]),
         .res (lane_out[8*l +: 8])
      );
   end

   for (genvar p = 0; p < DIGEST_BYTES; p++) begin : g_byte
      assign next_h[8*(DIGEST_BYTES-1-p) +: 8] = (rnd == RW'(p / LANES))
                                               ? lane_out[8*(p % LANES) +: 8]
                                               : shadow[8*(DIGEST_BYTES-1-p) +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ACCEPT;
         rnd            <= '0;
         h              <= IV;
         shadow         <= IV;
         msg_byte       <= 8'h00;
         last_q         <= 1'b0;
         len            <= 16'd0;
         bus.in_ready   <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_digest <= '0;
         bus.out_len    <= 16'd0;
         bus.err        <= 1'b0;
      end else begin
         bus.err <= 1'b0;
         case (state)
            ACCEPT: begin
               bus.in_ready <= 1'b1;
               if (hs) begin
                  if ((len == 16'(MAX_LEN)) || bad) begin
                     bus.err <= 1'b1;
                     if (bus.in_last) begin
                        h   <= IV;
                        len <= 16'd0;
                     end else begin
                        state <= DRAIN;
                     end
                  end else begin
                     msg_byte     <= bus.in_data;
                     last_q       <= bus.in_last;
                     len          <= len + 16'd1;
                     rnd          <= '0;
                     state        <= ROUND;
                     bus.in_ready <= 1'b0;
                  end
               end
            end
            ROUND: begin
               shadow <= next_h;
               if (rnd == RW'(K - 1)) begin
                  h   <= next_h;
                  rnd <= '0;
                  if (last_q) begin
                     state          <= DONE;
                     bus.out_valid  <= 1'b1;
                     bus.out_digest <= next_h;
                     bus.out_len    <= len;
                  end else begin
                     state        <= ACCEPT;
                     bus.in_ready <= 1'b1;
                  end
               end else begin
                  rnd <= rnd + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  h             <= IV;
                  len           <= 16'd0;
                  state         <= ACCEPT;
               end
            end
            DRAIN: begin
               if (hs && bus.in_last) begin
                  h     <= IV;
                  len   <= 16'd0;
                  state <= ACCEPT;
               end
            end
            default: state <= ACCEPT;
         endcase
      end
   end
endmodule

// File: tb/tb_lh_stream_hasher.sv
// Scoreboard bench for lh_stream_hasher: default build plus two N=16 instances.
module tb_lh_stream_hasher;
   import lh_pkg::*;

   localparam int W = 144;
   localparam logic [127:0] IV8  = 128'(LH_DEFAULT_IV);
   localparam logic [127:0] IV16 = 128'h0123_4567_89AB_CDEF_3455_0F14_DAC0_2BEE;
`ifdef LH_INPUT_FILTER_EN
   localparam logic [7:0] FIRST_BYTE = 8'h41;
`else
   localparam logic [7:0] FIRST_BYTE = 8'h00;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   lh_stream_hasher_if #(.DIGEST_BYTES(8))  b8 ();
   lh_stream_hasher_if #(.DIGEST_BYTES(16)) b16a ();
   lh_stream_hasher_if #(.DIGEST_BYTES(16)) b16b ();
   lh_state_e st8, st16a, st16b;

   lh_stream_hasher u8 (.clk(clk), .rst(rst), .bus(b8.slave), .fsm_state(st8));
   lh_stream_hasher #(.DIGEST_BYTES(16), .LANES(4), .IV(IV16))
      u16a (.clk(clk), .rst(rst), .bus(b16a.slave), .fsm_state(st16a));
   lh_stream_hasher #(.DIGEST_BYTES(16), .LANES(1), .IV(IV16))
      u16b (.clk(clk), .rst(rst), .bus(b16b.slave), .fsm_state(st16b));

   // scoreboard
   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp8_q[$];
   logic [W-1:0] exp16a_q[$];
   logic [W-1:0] exp16b_q[$];
   int err_cnt = 0;
   int ov8_cnt = 0;
   logic [511:0] mbuf;
   int mlen;
   int prev_hs, last_hs;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_of(input logic [127:0] iv, input int n);
      return W'({lh_ref_digest(iv, n, mbuf, mlen), 16'(mlen)});
   endfunction

   task automatic load_str(input string s);
      mbuf = '0;
      mlen = s.len();
      for (int i = 0; i < mlen; i++) mbuf[8*i +: 8] = s[i];
   endtask

   always @(negedge clk) begin
      if (b8.err) err_cnt++;
      if (b8.out_valid) ov8_cnt++;
      if (!rst && b8.out_valid && b8.out_ready) begin
         if (exp8_q.size() == 0) check("sb8_pending", W'(exp8_q.size()), W'(1));
         else check("sb8_digest", W'({b8.out_digest, b8.out_len}), exp8_q.pop_front());
      end
      if (!rst && b16a.out_valid && b16a.out_ready) begin
         if (exp16a_q.size() == 0) check("sb16a_pending", W'(exp16a_q.size()), W'(1));
         else check("sb16a_digest", W'({b16a.out_digest, b16a.out_len}), exp16a_q.pop_front());
      end
      if (!rst && b16b.out_valid && b16b.out_ready) begin
         if (exp16b_q.size() == 0) check("sb16b_pending", W'(exp16b_q.size()), W'(1));
         else check("sb16b_digest", W'({b16b.out_digest, b16b.out_len}), exp16b_q.pop_front());
      end
   end

   // drivers: called and returning just after a rising edge
   task automatic send8(input logic [7:0] d, input logic l);
      int cnt = 0;
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      b8.in_last  = l;
      @(negedge clk);
      while (!b8.in_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 200) check("send8_ready", W'(b8.in_ready), W'(1));
      @(posedge clk);
      #1;
      prev_hs     = last_hs;
      last_hs     = cyc;
      b8.in_valid = 1'b0;
   endtask

   task automatic send_msg8(input logic with_last);
      for (int i = 0; i < mlen; i++) begin
         if (with_last && i == mlen - 1) exp8_q.push_back(exp_of(IV8, 8));
         send8(mbuf[8*i +: 8], with_last && (i == mlen - 1));
      end
   endtask

   task automatic send16(input logic sel, input logic [7:0] d, input logic l);
      int cnt = 0;
      b16a.in_data = d;
      b16b.in_data = d;
      b16a.in_last = l;
      b16b.in_last = l;
      if (sel) b16b.in_valid = 1'b1;
      else     b16a.in_valid = 1'b1;
      @(negedge clk);
      while (!(sel ? b16b.in_ready : b16a.in_ready) && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 200) check("send16_ready", W'(sel ? b16b.in_ready : b16a.in_ready), W'(1));
      @(posedge clk);
      #1;
      b16a.in_valid = 1'b0;
      b16b.in_valid = 1'b0;
   endtask

   task automatic wait_ov8(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b8.out_valid && n < 100);
      if (!b8.out_valid) check("ov8_timeout", W'(b8.out_valid), W'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  W'(b8.in_ready), W'(0));
      check({tag, "_out_valid"}, W'(b8.out_valid), W'(0));
      check({tag, "_err"},       W'(b8.err), W'(0));
      check({tag, "_digest"},    W'(b8.out_digest), W'(0));
      check({tag, "_len"},       W'(b8.out_len), W'(0));
      check({tag, "_state"},     W'(st8), W'(ACCEPT));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lows, e0, o0;
      logic [W-1:0] e;
      b8.in_valid = 0;   b8.in_data = 0;   b8.in_last = 0;   b8.out_ready = 1;
      b16a.in_valid = 0; b16a.in_data = 0; b16a.in_last = 0; b16a.out_ready = 1;
      b16b.in_valid = 0; b16b.in_data = 0; b16b.in_last = 0; b16b.out_ready = 1;
      prev_hs = 0;
      last_hs = 0;

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", W'(b8.in_ready), W'(0));
      @(negedge clk);
      check("ready_rise", W'(b8.in_ready), W'(1));
      @(posedge clk); #1;

      // single byte message
      mbuf = '0;
      mbuf[7:0] = FIRST_BYTE;
      mlen = 1;
      exp8_q.push_back(exp_of(IV8, 8));
      send8(FIRST_BYTE, 1'b1);
      n = 0;
      lows = 0;
      do begin
         @(negedge clk);
         n++;
         if (n <= 8 && !b8.in_ready) lows++;
      end while (!b8.out_valid && n < 100);
      check("t1_latency", W'(n), W'(9));
      check("t1_ready_low", W'(lows), W'(8));
`ifndef LH_INPUT_FILTER_EN
      check("t1_top_byte", W'(b8.out_digest[63:56]), W'(8'h76));
`endif
      check("t1_len", W'(b8.out_len), W'(1));
      @(posedge clk); #1;

      // 32-byte message, consumer stalls for 20 cycles
      b8.out_ready = 1'b0;
      load_str("The quick brown fox jumps over t");
      e = exp_of(IV8, 8);
      send_msg8(1'b1);
      check("t2_byte_gap", W'(last_hs - prev_hs), W'(9));
      wait_ov8(n);
      repeat (20) begin
         check("t2_hold", W'({b8.out_digest, b8.out_len}), e);
         check("t2_valid", W'(b8.out_valid), W'(1));
         check("t2_no_ready", W'(b8.in_ready), W'(0));
         @(negedge clk);
      end
      @(posedge clk); #1 b8.out_ready = 1'b1;
      @(posedge clk); #1;

      // 33-byte overflow, drain, then a fresh message
      load_str("0123456789abcdefghijklmnopqrstuvwxyz");
      e0 = err_cnt;
      o0 = ov8_cnt;
      for (int i = 0; i < 33; i++) send8(mbuf[8*i +: 8], 1'b0);
      @(negedge clk);
      check("t3_err_pulse", W'(b8.err), W'(1));
      check("t3_drain", W'(st8), W'(DRAIN));
      @(posedge clk); #1;
      for (int i = 33; i < 36; i++) send8(mbuf[8*i +: 8], i == 35);
      repeat (3) @(negedge clk);
      check("t3_err_once", W'(err_cnt - e0), W'(1));
      check("t3_no_out", W'(ov8_cnt - o0), W'(0));
      check("t3_accept", W'(st8), W'(ACCEPT));
      @(posedge clk); #1;
      mbuf = '0;
      mbuf[7:0] = FIRST_BYTE;
      mlen = 1;
      send_msg8(1'b1);
      wait_ov8(n);
      @(posedge clk); #1;

      // N=16 with 4 lanes and with 1 lane
      load_str("Hash!");
      for (int s = 0; s < 2; s++) begin
         if (s == 0) exp16a_q.push_back(exp_of(IV16, 16));
         else        exp16b_q.push_back(exp_of(IV16, 16));
         for (int i = 0; i < mlen; i++) send16(s[0], mbuf[8*i +: 8], i == mlen - 1);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(s == 0 ? b16a.out_valid : b16b.out_valid) && n < 100);
         if (s == 0) check("t4_latency_l4", W'(n), W'(5));
         else        check("t4_latency_l1", W'(n), W'(17));
         @(posedge clk); #1;
      end

      // reset during the round of the third byte
      load_str("Reset");
      e0 = err_cnt;
      for (int i = 0; i < 3; i++) send8(mbuf[8*i +: 8], 1'b0);
      @(negedge clk);
      check("t5_in_round", W'(st8), W'(ROUND));
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("t5_rst");
      @(negedge clk);
      check("t5_ready_rise", W'(b8.in_ready), W'(1));
      check("t5_no_err", W'(err_cnt - e0), W'(0));
      @(posedge clk); #1;
      send_msg8(1'b1);
      wait_ov8(n);
      @(posedge clk); #1;

      // 0x7F in the middle of a message
      mbuf = '0;
      mbuf[39:0] = 40'h64_63_7F_62_61;
      mlen = 5;
      e0 = err_cnt;
      o0 = ov8_cnt;
`ifdef LH_INPUT_FILTER_EN
      for (int i = 0; i < mlen; i++) send8(mbuf[8*i +: 8], i == mlen - 1);
      repeat (12) @(negedge clk);
      check("t6_err", W'(err_cnt - e0), W'(1));
      check("t6_no_out", W'(ov8_cnt - o0), W'(0));
`else
      send_msg8(1'b1);
      wait_ov8(n);
      check("t6_no_err", W'(err_cnt - e0), W'(0));
`endif
      @(posedge clk); #1;

      repeat (5) @(negedge clk);
      check("sb8_empty", W'(exp8_q.size()), W'(0));
      check("sb16a_empty", W'(exp16a_q.size()), W'(0));
      check("sb16b_empty", W'(exp16b_q.size()), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
